pwm_cmd_decoder: RTL
====================

Name: pwm_cmd_decoder

Overview:
- Receiving end of the motor-drive command interface: one PWM line plus an A/B direction pin pair per motor.
- Measures PWM high time and period in clk cycles, decodes the direction pins into a drive mode, and flags a stuck PWM line.
- Used as the motor-side monitor/loopback checker on the rover: it confirms on hardware what the drive logic commands.
- One instance per motor channel.

Parameters:
- CNT_W, 23, width of all cycle counters and measurement outputs.
- TIMEOUT, 2500000, cycles without a PWM edge before the stuck flag sets (1.5x the 60 Hz period at 100 MHz).
- FILT_LEN, 4, glitch-filter stability length in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- pwm_in  in  1  PWM command line, asynchronous to clk.
- in_a  in  1  direction pin A, asynchronous.
- in_b  in  1  direction pin B, asynchronous.
- high_cnt  out  CNT_W  last measured high time in cycles.
- period_cnt  out  CNT_W  last measured rise-to-rise period in cycles.
- meas_valid  out  1  one-cycle strobe; high_cnt and period_cnt were just updated.
- dir  out  2  drive mode: 00 coast, 01 forward, 10 reverse, 11 brake.
- dir_chg  out  1  one-cycle strobe on any change of dir.
- stuck  out  1  no PWM edge for TIMEOUT cycles.
- stuck_level  out  1  synchronised pwm_in level when stuck set.

Behaviour:
- Reset, asynchronous, rst_n low: all outputs 0; FSM in SEEK; counters 0; synchroniser flops 0.
- Synchronisation: pwm_in, in_a and in_b each pass through 2 flops. Rise and fall are detected on the synchronised pwm (previous vs current).
- Counter cnt: cleared to 1 on an accepted rise; otherwise increments each cycle; saturates at all-ones and never wraps.
- FSM SEEK: ignores falls. On rise, go to HIGH (cnt=1). Measurement outputs are not updated.
- FSM HIGH: on fall, high_lat <= cnt, go to LOW.
- FSM LOW: on rise:
  - high_cnt <= high_lat, period_cnt <= cnt.
  - meas_valid=1 for exactly one cycle (registered, the cycle after rise detection).
  - cnt=1, go to HIGH.
- Latency: pwm_in rising edge to meas_valid is 4 clk cycles: 2 sync + 1 detect + 1 output register.
- Simultaneous rise and timeout in the same cycle: the rise wins, stuck does not set.
- Timeout:
  - In HIGH or LOW, if cnt reaches TIMEOUT, then stuck<=1, stuck_level<=synced pwm, high_cnt<=0, period_cnt<=0, state SEEK. No meas_valid.
  - In SEEK, the timeout also applies, since cnt runs from reset. A line constant from reset sets stuck after TIMEOUT cycles.
- Stuck clear: the next accepted rise clears stuck and stuck_level. The FSM goes to HIGH; the first full period after recovery produces the next meas_valid.
- Duty 0% or 100% is therefore reported only via stuck, with stuck_level 0 or 1.
- Direction:
  - dir <= {sync_a, sync_b} mapped as: a=0,b=1 -> 01 forward; a=1,b=0 -> 10 reverse; 00 -> 00 coast; 11 -> 11 brake.
  - Registered one cycle after sync.
  - dir_chg=1 for one cycle when the new dir differs from the previous dir. No dir_chg on the first cycle after reset.
- Reset mid-measurement: everything is discarded immediately; no stale meas_valid after release.

Optional Feature:
- Macro PWM_GLITCH_FILTER_EN.
- Defined: the synced pwm is accepted as a new level only after FILT_LEN consecutive identical samples. Pulses shorter than FILT_LEN cycles are ignored. Measured values are unchanged for clean input, since both edges are delayed equally. Latency to meas_valid becomes 4+FILT_LEN cycles. in_a and in_b are filtered the same way.
- Undefined: no filter; 4-cycle latency; every synchronised edge is accepted.

Test Plan:
1. Reset, then PWM period 1666668 with high 833334 (50%): second and later rises give high_cnt=833334, period_cnt=1666668, one meas_valid per period; first rise gives none.
2. Period 1666668 with high 500000: high_cnt=500000, period_cnt=1666668; check meas_valid 4 cycles after pwm_in rise.
3. pwm_in held low after a valid period: stuck=1, stuck_level=0 exactly TIMEOUT cycles after the last rise, outputs 0. Resume PWM: stuck clears on the first rise, and meas_valid returns one period later.
4. pwm_in constant high from reset: stuck=1, stuck_level=1 after TIMEOUT cycles; no meas_valid at any point.
5. in_a/in_b sequence 01, 10, 00, 11, held 10 cycles each: dir follows 01, 10, 00, 11 with 3-cycle latency; dir_chg pulses once per change.
6. rst_n asserted mid-HIGH: all outputs 0 immediately. With PWM_GLITCH_FILTER_EN, a 2-cycle low glitch inside the high phase leaves high_cnt unchanged; without it, that glitch produces a short high_cnt.

Source files
------------

// File: rtl/pwm_cmd_decoder.sv
// Motor command monitor: measures PWM high time and period, decodes A/B pins into a drive mode, flags a stuck PWM line.
// Optional macro PWM_GLITCH_FILTER_EN adds a FILT_LEN-sample stability filter on all three synchronised inputs.
module pwm_cmd_decoder #(
    parameter int CNT_W    = 23,
    parameter int TIMEOUT  = 2500000,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             in_a,
    input  logic             in_b,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic [1:0]       dir,
    output logic             dir_chg,
    output logic             stuck,
    output logic             stuck_level
);

    if (FILT_LEN < 1) begin : g_bad_filt
        $error("FILT_LEN must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    // Bit order throughout: {pwm, a, b}
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {pwm_in, in_a, in_b};
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic [2:0]         filt_q;
    logic [2:0][FW-1:0] fcnt_q;

    // A new level is taken only after FILT_LEN consecutive samples disagree with the held one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILT_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    logic pwm_prev_q, rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            pwm_prev_q <= lvl[2];
            rise_q     <= lvl[2] & ~pwm_prev_q;
            fall_q     <= ~lvl[2] & pwm_prev_q;
        end
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_lat_q, high_lat_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             meas_valid_q, meas_valid_d;
    logic             stuck_q, stuck_d;
    logic             stuck_level_q, stuck_level_d;
    logic [1:0]       dir_q;
    logic             dir_chg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEEK;
            cnt_q         <= '0;
            high_lat_q    <= '0;
            high_cnt_q    <= '0;
            period_cnt_q  <= '0;
            meas_valid_q  <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
            dir_q         <= 2'b00;
            dir_chg_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            high_lat_q    <= high_lat_d;
            high_cnt_q    <= high_cnt_d;
            period_cnt_q  <= period_cnt_d;
            meas_valid_q  <= meas_valid_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
            dir_q         <= lvl[1:0];
            dir_chg_q     <= (lvl[1:0] != dir_q);
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        high_lat_d    = high_lat_q;
        high_cnt_d    = high_cnt_q;
        period_cnt_d  = period_cnt_q;
        meas_valid_d  = 1'b0;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;

        // A rise always wins over a coincident timeout.
        if (rise_q) begin
            cnt_d         = CNT_W'(1);
            state_d       = HIGH;
            stuck_d       = 1'b0;
            stuck_level_d = 1'b0;
            if (state_q == LOW) begin
                high_cnt_d   = high_lat_q;
                period_cnt_d = cnt_q;
                meas_valid_d = 1'b1;
            end
        end else begin
            if (fall_q && state_q == HIGH) begin
                high_lat_d = cnt_q;
                state_d    = LOW;
            end
            // Once stuck, the flag and captured level hold until the next rise.
            if (!stuck_q && cnt_q >= TO) begin
                stuck_d       = 1'b1;
                stuck_level_d = lvl[2];
                high_cnt_d    = '0;
                period_cnt_d  = '0;
                state_d       = SEEK;
            end
        end
    end

    assign high_cnt    = high_cnt_q;
    assign period_cnt  = period_cnt_q;
    assign meas_valid  = meas_valid_q;
    assign dir         = dir_q;
    assign dir_chg     = dir_chg_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule
